// File: rtl/pipe_adder_pkg.sv
// ----------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared constants and helpers for the pipelined carry adder.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth.
//   slice_w(width, stages) : bits handled by one pipeline stage.
// ----------------------------------------------------------------------------
package pipe_adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  function automatic int slice_w(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// ----------------------------------------------------------------------------
// adder_slice
//   One registered pipeline stage of the carry-chained adder: adds one
//   SLICE-bit pair of operand slices plus the incoming carry and holds the
//   result together with its valid bit.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   v_i          : upstream stage (or input port) holds a valid item
//   rdy_i        : this stage may load this cycle (it is empty or draining)
//   a_i, b_i     : operand slices belonging to this stage
//   c_i          : carry from the previous stage (carry-in for stage 0)
//   v_o          : registered valid bit of this stage
//   s_o          : registered partial sum slice
//   c_o          : registered carry out of this slice
// ----------------------------------------------------------------------------
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             v_i,
  input  logic             rdy_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             c_i,
  output logic             v_o,
  output logic [SLICE-1:0] s_o,
  output logic             c_o
);

  logic             v_q;
  logic             c_q;
  logic             c_d;
  logic [SLICE-1:0] s_q;
  logic [SLICE-1:0] s_d;

  always_comb begin
    {c_d, s_d} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE{1'b0}}, c_i};
  end

  // When rdy_i is high an empty upstream slot loads as a bubble (v_q=0) and
  // the data registers keep their old value; when rdy_i is low everything holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      s_q <= '0;
      c_q <= 1'b0;
    end else if (rdy_i) begin
      v_q <= v_i;
      if (v_i) begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end
  end

  assign v_o = v_q;
  assign s_o = s_q;
  assign c_o = c_q;

endmodule

// File: rtl/pipe_carry_adder.sv
// ----------------------------------------------------------------------------
// pipe_carry_adder
//   Pipelined WIDTH-bit adder: sum = (a + b + cin) mod 2^WIDTH, cout = carry
//   out of bit WIDTH-1. The addition is split into STAGES slices of
//   WIDTH/STAGES bits, one slice added per stage, carry rippling stage to stage.
//   Latency is STAGES cycles, throughput one result per cycle.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high (in_valid & in_ready on the input, out_valid & out_ready on the
//   output). A stage advances when it is empty or the stage after it advances,
//   so bubbles collapse and a full pipeline under stall holds all registers.
//   in_ready depends combinationally on out_ready.
//
// Optional feature: define PIPE_ADDER_OVF_EN to add the ovf port (signed
//   overflow of the sum, aligned with out_valid).
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake for a, b, cin
//   a, b                 : unsigned WIDTH-bit operands
//   cin                  : carry-in
//   out_valid / out_ready: output handshake for sum, cout (and ovf)
//   sum, cout            : result from the last stage register
//   ovf                  : signed overflow (PIPE_ADDER_OVF_EN only)
// ----------------------------------------------------------------------------
module pipe_carry_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SLICE = slice_w(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if ((STAGES < 1) || (STAGES > WIDTH) || (WIDTH % STAGES != 0)) begin : g_bad_cfg
    $error("pipe_carry_adder: WIDTH (%0d) must be a non-zero multiple of STAGES (%0d)",
           WIDTH, STAGES);
  end

  // Per-stage state. a_q/b_q carry the whole operands down the pipe so later
  // stages can pick their slice; lo_q holds the sum bits finished upstream.
  logic             v     [STAGES];
  logic             c     [STAGES];
  logic [SLICE-1:0] s     [STAGES];
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] lo_q  [STAGES];
  logic [WIDTH-1:0] sum_w [STAGES];
  logic             rdy   [STAGES+1];

  // Ready chain, evaluated from the output back to the input.
  always_comb begin
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_src;
    logic             c_src;
    logic [WIDTH-1:0] a_src;
    logic [WIDTH-1:0] b_src;
    logic [WIDTH-1:0] lo_src;

    if (k == 0) begin : g_first
      assign v_src  = in_valid;
      assign c_src  = cin;
      assign a_src  = a;
      assign b_src  = b;
      assign lo_src = '0;
    end else begin : g_next
      assign v_src  = v[k-1];
      assign c_src  = c[k-1];
      assign a_src  = a_q[k-1];
      assign b_src  = b_q[k-1];
      assign lo_src = sum_w[k-1];
    end

    adder_slice #(
      .SLICE (SLICE)
    ) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .v_i   (v_src),
      .rdy_i (rdy[k]),
      .a_i   (a_src[k*SLICE +: SLICE]),
      .b_i   (b_src[k*SLICE +: SLICE]),
      .c_i   (c_src),
      .v_o   (v[k]),
      .s_o   (s[k]),
      .c_o   (c[k])
    );

    // Sideband registers load under the same condition as the slice data.
    // The last stage's operand copy is only read for the overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q[k]  <= '0;
        b_q[k]  <= '0;
        lo_q[k] <= '0;
      end else if (rdy[k] && v_src) begin
        a_q[k]  <= a_src;
        b_q[k]  <= b_src;
        lo_q[k] <= lo_src;
      end
    end

    // lo_q only ever has bits below k*SLICE set, so OR merges the new slice.
    assign sum_w[k] = lo_q[k] | (WIDTH'(s[k]) << (k * SLICE));
  end

  assign in_ready  = rdy[0];
  assign out_valid = v[LAST];
  assign sum       = sum_w[LAST];
  assign cout      = c[LAST];

`ifdef PIPE_ADDER_OVF_EN
  assign ovf = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
               (sum_w[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
`endif

endmodule

// File: tb/tb_pipe_carry_adder.sv
module tb_pipe_carry_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int EW     = WIDTH + 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf_w;

  always #5 clk = ~clk;

`ifdef PIPE_ADDER_OVF_EN
  logic ovf;
  assign ovf_w = ovf;
`else
  assign ovf_w = 1'b0;
`endif

  pipe_carry_adder #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef PIPE_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int check_cnt  = 0;
  int pass_cnt   = 0;
  int stall_cnt  = 0;
  int accept_cnt = 0;
  int out_cnt    = 0;
  bit rand_ready = 1'b0;
  bit hold_pending = 1'b0;
  logic [EW-1:0] held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [EW-1:0] ref_model(input logic [WIDTH-1:0] ta,
                                              input logic [WIDTH-1:0] tb_,
                                              input logic tc);
    longint unsigned total;
    longint sa, sb, st, half;
    logic o;
    logic co;
    logic [WIDTH-1:0] s;
    half  = longint'(1) << (WIDTH - 1);
    total = longint'(ta) + longint'(tb_) + longint'(tc);
    co    = (total >= (longint'(1) << WIDTH));
    s     = total[WIDTH-1:0];
    sa    = (longint'(ta)  >= half) ? longint'(ta)  - 2 * half : longint'(ta);
    sb    = (longint'(tb_) >= half) ? longint'(tb_) - 2 * half : longint'(tb_);
    st    = sa + sb + longint'(tc);
    o     = (st > half - 1) || (st < -half);
`ifndef PIPE_ADDER_OVF_EN
    o = 1'b0;
`endif
    return {o, co, s};
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc);
    int waited = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    cin = tc;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(ref_model(ta, tb_, tc));
        accept_cnt++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        return;
      end
      stall_cnt++;
      waited++;
      if (waited > 300) begin
        check("accept_timeout", 64'(waited), 64'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      cur = {ovf_w, cout, sum};
      if (hold_pending) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        check("hold_data", 64'(cur), 64'(held));
        hold_pending = 1'b0;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(cur), 64'(0) - 64'(1));
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(cur), 64'(e));
        end
      end else if (out_valid) begin
        held = cur;
        hold_pending = 1'b1;
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int acc0;
    int out0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_ovf", 64'(ovf_w), 64'(0));
    @(posedge clk);
    #1;

    // Latency with an empty pipeline
    out_ready = 1'b1;
    send(16'h1234, 16'h1111, 1'b0);
    cnt = 1;
    @(negedge clk);
    while (!out_valid && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("latency", 64'(cnt), 64'(STAGES));
    check("latency_sum", 64'(sum), 64'h2345);
    @(posedge clk);
    #1;
    wait_drain();

    // Carry ripple and overflow corner cases
    send(16'hFFFF, 16'h0000, 1'b1);
    send(16'h8000, 16'h8000, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0);
    send(16'h8000, 16'hFFFF, 1'b0);
    send(16'h0001, 16'h0001, 1'b0);
    send(16'hFFFF, 16'hFFFF, 1'b1);
    send(16'h7FFF, 16'h0000, 1'b1);
    wait_drain();

    // Backpressure: 8 operands against a stalled output
    out_ready = 1'b0;
    acc0 = accept_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(negedge clk);
        check("bp_accepts", 64'(accept_cnt - acc0), 64'(STAGES));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // Full throughput: 100 back-to-back operands
    stall_cnt = 0;
    out0 = out_cnt;
    for (int i = 0; i < 100; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    check("tput_stalls", 64'(stall_cnt), 64'(0));
    check("tput_outputs", 64'(out_cnt - out0), 64'(100 - STAGES));
    wait_drain();

    // Random gaps on input, random backpressure on output
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset mid-stream with 3 items in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(WIDTH'($urandom_range(1, 65535)), WIDTH'($urandom), 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_valid", 64'(out_valid), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 64'(out_valid), 64'(0));
    check("mid_reset_sum", 64'(sum), 64'(0));
    check("mid_reset_cout", 64'(cout), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("post_reset_no_stale", 64'(cnt), 64'(0));
    check("post_reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    send(16'hABCD, 16'h1234, 1'b1);
    wait_drain();

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
